// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and the data stage.
// Data has priority, fetch has a starvation guard, and every transaction is bounded by a timeout.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int FAIR_W = $clog2(FAIR_MAX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state_q, state_d;
  logic [FAIR_W-1:0] fair_q, fair_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;

  logic              err_c;
  logic              data_req, fetch_ok, can_grant, done_ok, finish;
  logic [DATA_W-1:0] done_data;

  assign data_req  = d_rd | d_wr;
  assign fetch_ok  = if_req & ~halt;
  // The valid-pulse cycle never grants, so a requester sees its completion before re-arbitration.
  assign can_grant = (state_q == IDLE) & ~if_valid_q & ~d_valid_q;
  assign done_ok   = mem_done & ~mem_en_q;
  assign finish    = done_ok | (tmo_q == TMO_W'(TIMEOUT));
  assign done_data = done_ok ? mem_rdata : '0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    fair_d      = fair_q;
    tmo_d       = tmo_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    err_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_grant) begin
          if (data_req && !(fetch_ok && fair_q == FAIR_W'(FAIR_MAX))) begin
            state_d     = BUSY_D;
            mem_en_d    = 1'b1;
            mem_wr_d    = d_wr;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            tmo_d       = '0;
            err_c       = d_rd & d_wr;
            if (!if_req)                          fair_d = '0;
            else if (fair_q != FAIR_W'(FAIR_MAX)) fair_d = fair_q + 1'b1;
          end else if (fetch_ok) begin
            state_d    = BUSY_I;
            mem_en_d   = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = if_addr;
            tmo_d      = '0;
            fair_d     = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) begin
          state_d = IDLE;
          err_c   = ~done_ok;
          if (state_q == BUSY_I) begin
            if_rdata_d = done_data;
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = done_data;
            d_valid_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fair_q      <= '0;
      tmo_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fair_q      <= fair_d;
      tmo_q       <= tmo_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_stall   = data_req & ~d_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_c & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios pinned by literals, then randomized traffic
// against a transaction-timeline model with a small behavioural memory.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16, FAIR_MAX = 4, TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1, halt = 1'b0, if_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0, mem_done = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0, mem_addr;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0, if_rdata, d_rdata, mem_wdata;
  logic if_valid, if_stall, d_valid, d_stall, mem_en, mem_wr, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR_MAX(FAIR_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .halt(halt), .if_req(if_req), .if_addr(if_addr),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
  );

  int checks = 0, failures = 0;
  int t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Behavioural memory: 16 words indexed by the low address bits; writes land at issue.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] mem_old = '0;
  int lat_fixed = 1;   // >0 fixed latency, 0 never answers, -1 random
  int done_at = -1;

  task automatic mem_capture();
    int l;
    logic [3:0] idx;
    if (mem_en === 1'b1) begin
      idx = mem_addr[3:0];
      mem_old = mem[idx];
      if (mem_wr === 1'b1) mem[idx] = mem_wdata;
      l = lat_fixed;
      if (l < 0) begin
        case ($urandom_range(0, 11))
          7:       l = 2;
          8:       l = 3;
          9:       l = 5;
          10:      l = TIMEOUT;
          11:      l = ($urandom_range(0, 1) != 0) ? TIMEOUT + 1 : 0;
          default: l = 1;
        endcase
      end
      done_at = (l == 0) ? -1 : t + l;
    end
  endtask

  // Reference model: a timeline of the one outstanding transaction plus the held output values.
  logic [DW-1:0] sh [16];
  bit            a_act = 1'b0, a_data = 1'b0;
  int            a_en = 0;
  logic [DW-1:0] a_exp = '0;
  int            v_at = -1;
  bit            v_data = 1'b0;
  int            fair = 0;
  logic [DW-1:0] m_ird = '0, m_drd = '0, m_mwd = '0;
  logic [AW-1:0] m_maddr = '0;
  bit            m_mwr = 1'b0;
  bit            e_ivalid = 1'b0, e_dvalid = 1'b0;

  task automatic model_step();
    bit e_en, e_err, gd, gi, fin, done_ok;
    logic [AW-1:0] ga;
    e_en     = a_act && (t == a_en);
    e_ivalid = (v_at == t) && !v_data;
    e_dvalid = (v_at == t) && v_data;
    done_ok  = a_act && (t > a_en) && (mem_done === 1'b1);
    fin      = a_act && (done_ok || (t - a_en == TIMEOUT));
    gd = 1'b0;
    gi = 1'b0;
    if (!a_act && v_at != t) begin
      if ((d_rd || d_wr) && !(if_req && !halt && fair == FAIR_MAX)) gd = 1'b1;
      else if (if_req && !halt)                                      gi = 1'b1;
    end
    e_err = (fin && !done_ok) || (gd && d_rd && d_wr);

    if (!rst) begin
      check("mem_en", mem_en, e_en);
      check("mem_wr", mem_wr, m_mwr);
      check("mem_addr", mem_addr, m_maddr);
      check("mem_wdata", mem_wdata, m_mwd);
      check("if_valid", if_valid, e_ivalid);
      check("d_valid", d_valid, e_dvalid);
      check("if_rdata", if_rdata, m_ird);
      check("d_rdata", d_rdata, m_drd);
      check("if_stall", if_stall, if_req && !e_ivalid);
      check("d_stall", d_stall, (d_rd || d_wr) && !e_dvalid);
      check("err", err, e_err);
    end

    if (rst) begin
      a_act = 1'b0; v_at = -1; fair = 0;
      m_ird = '0; m_drd = '0; m_mwd = '0; m_maddr = '0; m_mwr = 1'b0;
    end else begin
      if (fin) begin
        v_at   = t + 1;
        v_data = a_data;
        if (a_data) m_drd = done_ok ? a_exp : '0;
        else        m_ird = done_ok ? a_exp : '0;
        a_act = 1'b0;
      end
      if (gd || gi) begin
        ga      = gd ? d_addr : if_addr;
        a_act   = 1'b1;
        a_data  = gd;
        a_en    = t + 1;
        m_maddr = ga;
        m_mwr   = gd && d_wr;
        if (gd) m_mwd = d_wdata;
        a_exp = sh[ga[3:0]];
        if (m_mwr) sh[ga[3:0]] = d_wdata;
        if (gi || !if_req)        fair = 0;
        else if (fair < FAIR_MAX) fair++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    mem_capture();
    @(posedge clk);
    #1;
    t++;
    mem_done  = (t == done_at);
    mem_rdata = mem_done ? mem_old : 16'($urandom);
  endtask

  task automatic rand_drive();
    int op;
    if (!if_req || e_ivalid || $urandom_range(0, 39) == 0) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = 16'($urandom);
    end
    if (!(d_rd || d_wr) || e_dvalid || $urandom_range(0, 39) == 0) begin
      op      = $urandom_range(0, 15);
      d_rd    = (op <= 5);
      d_wr    = (op == 0) || (op >= 6 && op <= 10);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
    end
    if ($urandom_range(0, 63) == 0) halt = ~halt;
    rst = ($urandom_range(0, 599) == 0);
  endtask

  initial begin
    int ngr, cnt;
    bit got;
    logic [6:0] pat;

    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'(16'h1111 * i) ^ 16'h5A5A;
      sh[i]  = mem[i];
    end
    mem[0] = 16'h4005;
    sh[0]  = 16'h4005;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_valid", d_valid, 0);
    tick();

    // Lone fetch with a 1-cycle memory.
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 16'h0010);
    tick();
    check("t1_early_valid", if_valid, 0);
    check("t1_stall", if_stall, 1);
    tick();
    check("t1_if_valid", if_valid, 1);
    check("t1_if_rdata", if_rdata, 16'h4005);
    if_req = 1'b0;
    repeat (2) tick();

    // Store and fetch together: store first.
    if_req = 1'b1; if_addr = 16'h0020;
    d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    tick();
    check("t2_mem_wr", mem_wr, 1);
    check("t2_mem_addr", mem_addr, 16'h0200);
    check("t2_mem_wdata", mem_wdata, 16'hBEEF);
    repeat (2) tick();
    check("t2_d_valid", d_valid, 1);
    check("t2_if_not_yet", if_valid, 0);
    d_wr = 1'b0;
    repeat (2) tick();
    check("t2_fetch_wr", mem_wr, 0);
    check("t2_fetch_addr", mem_addr, 16'h0020);
    repeat (2) tick();
    check("t2_if_valid", if_valid, 1);
    check("t2_if_rdata", if_rdata, 16'hBEEF);
    if_req = 1'b0;
    repeat (2) tick();

    // Continuous data reads against a pending fetch: the fairness limit forces one fetch.
    if_req = 1'b1; if_addr = 16'h0030;
    d_rd = 1'b1; d_addr = 16'h0300;
    pat = '0;
    ngr = 0;
    for (int i = 0; i < 60 && ngr < 7; i++) begin
      tick();
      if (mem_en === 1'b1) begin
        pat = {pat[5:0], mem_addr == 16'h0300};
        ngr++;
      end
    end
    check("t3_grants", ngr, 7);
    check("t3_order", pat, 7'b1111011);
    if_req = 1'b0; d_rd = 1'b0;
    repeat (6) tick();

    // Memory never answers: timeout.
    lat_fixed = 0;
    d_rd = 1'b1; d_addr = 16'h0005;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1)  check("t4_mem_en", mem_en, 1);
      if (i == 15) check("t4_err_early", err, 0);
      if (i == 16) check("t4_err", err, 1);
    end
    tick();
    check("t4_d_valid", d_valid, 1);
    check("t4_d_rdata", d_rdata, 0);
    d_rd = 1'b0;
    lat_fixed = 1;
    repeat (2) tick();

    // Reset while a load is in flight; its mem_done arrives after reset.
    d_rd = 1'b1; d_addr = 16'h0007;
    tick();
    check("t5_mem_en", mem_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; d_rd = 1'b0;
    check("t5_mem_en0", mem_en, 0);
    check("t5_mem_addr0", mem_addr, 0);
    check("t5_mem_wdata0", mem_wdata, 0);
    check("t5_if_rdata0", if_rdata, 0);
    check("t5_d_rdata0", d_rdata, 0);
    tick();
    check("t5_no_valid", d_valid, 0);
    d_rd = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (d_valid === 1'b1) begin
        got = 1'b1;
        check("t5_d_rdata", d_rdata, 16'h2D2D);
      end
    end
    check("t5_served", got, 1);
    d_rd = 1'b0;
    repeat (2) tick();

    // Halt blocks fetch grants; data, including the illegal read+write, is still served.
    halt = 1'b1; if_req = 1'b1; if_addr = 16'h0040;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_en === 1'b1) cnt++;
    end
    check("t6_no_fetch", cnt, 0);
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0009; d_wdata = 16'h1234;
    #1;
    check("t6_err", err, 1);
    tick();
    check("t6_mem_wr", mem_wr, 1);
    repeat (2) tick();
    check("t6_d_valid", d_valid, 1);
    d_rd = 1'b0; d_wr = 1'b0;
    tick();
    d_rd = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (d_valid === 1'b1) begin
        got = 1'b1;
        check("t6_readback", d_rdata, 16'h1234);
      end
    end
    check("t6_read_served", got, 1);
    d_rd = 1'b0;
    halt = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (if_valid === 1'b1) got = 1'b1;
    end
    check("t6_fetch_after_halt", got, 1);
    if_req = 1'b0;
    repeat (2) tick();

    // Randomized traffic.
    lat_fixed = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rand_drive();
    end
    rst = 1'b0; halt = 1'b0; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    repeat (24) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
